// File: rtl/temp_fifo.sv
// temp_fifo: DEPTH-entry operand FIFO between the shared Data bus and the ULA input.
// Optional head readback onto Data is enabled by defining TEMP_READBACK_EN.
module temp_fifo #(
    parameter int Tamanho_Da_Palavra = 16,
    parameter int DEPTH              = 4,
    parameter int PTR_W              = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    inout  wire [Tamanho_Da_Palavra-1:0]  Data,
    input  logic                          io,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          ler,
    output logic [Tamanho_Da_Palavra-1:0] saidaUla,
    output logic [PTR_W:0]                count,
    output logic                          vazio,
    output logic                          cheio,
    output logic                          erro
);

    localparam int W = Tamanho_Da_Palavra;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             erro_q, erro_d;

    logic [W-1:0] data_in;
    logic         load_req;
    logic         push_eff;
    logic         pop_eff;
    logic         overflow;
    logic         underflow;

    assign data_in = Data;
    assign vazio   = (count_q == '0);
    assign cheio   = (count_q == FULL_COUNT);

    // A pop in the same edge frees the slot, so a full FIFO still accepts the push.
    assign load_req  = push & ~io;
    assign pop_eff   = pop & ~vazio;
    assign push_eff  = load_req & (~cheio | pop_eff);
    assign overflow  = load_req & cheio & ~pop_eff;
    assign underflow = pop & vazio;

    // NOTE: next-state logic is combinational; every _d gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        erro_d   = erro_q | overflow | underflow;

        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            erro_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            erro_q   <= erro_d;
        end
    end

    // NOTE: the storage array has no reset; count gates every observable read of it.
    always_ff @(posedge clock) begin
        if (!reset && push_eff) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign saidaUla = vazio ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign erro     = erro_q;

`ifdef TEMP_READBACK_EN
    // Enable is purely combinational, so the driver releases the bus the moment io falls.
    assign Data = (io & ler & ~vazio) ? mem_q[rd_ptr_q] : 'z;
`else
    logic unused_ler;
    assign unused_ler = ler;
    assign Data       = 'z;
`endif

endmodule

// File: tb/tb_temp_fifo.sv
// Self-checking bench for temp_fifo (W=16, DEPTH=4): directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_temp_fifo;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic [W-1:0] PROBE = 16'h0000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io    = 1'b0;
    logic          push  = 1'b0;
    logic          pop   = 1'b0;
    logic          ler   = 1'b0;
    logic          bus_en  = 1'b1;
    logic [W-1:0]  bus_drv = '0;
    wire  [W-1:0]  Data;
    logic [W-1:0]  saidaUla;
    logic [PTR_W:0] count;
    logic          vazio, cheio, erro;

    int total = 0;
    int bad   = 0;

    assign Data = bus_en ? bus_drv : 'z;

    always #5 clock = ~clock;

    temp_fifo #(
        .Tamanho_Da_Palavra(W),
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .Data(Data),
        .io(io),
        .push(push),
        .pop(pop),
        .ler(ler),
        .saidaUla(saidaUla),
        .count(count),
        .vazio(vazio),
        .cheio(cheio),
        .erro(erro)
    );

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic p, input logic q, input logic [W-1:0] d);
        io = 1'b0; ler = 1'b0; bus_en = 1'b1; bus_drv = d;
        push = p; pop = q;
        tick();
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must override a simultaneous push and pop.
        io = 1'b0; bus_en = 1'b1; bus_drv = 16'h5555; push = 1'b1; pop = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        total++;
        if (saidaUla !== 16'h0000) begin bad++; $display("FAIL reset_saida got=%h want=0000", saidaUla); end
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++;
        if ({vazio, cheio, erro} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b want=100", {vazio, cheio, erro}); end
        io = 1'b1; ler = 1'b1; bus_drv = PROBE;
        #1;
        total++;
        if (Data !== PROBE) begin bad++; $display("FAIL reset_bus_z got=%h want=%h", Data, PROBE); end
        io = 1'b0; ler = 1'b0;
    endtask

    task automatic test_push_pop();
        do_reset();
        drive(1'b1, 1'b0, 16'h1234);
        total++;
        if (saidaUla !== 16'h1234) begin bad++; $display("FAIL first_push_head got=%h want=1234", saidaUla); end
        drive(1'b1, 1'b0, 16'hABCD);
        total++;
        if (count !== 3'd2 || saidaUla !== 16'h1234) begin
            bad++; $display("FAIL two_push got count=%0d head=%h want count=2 head=1234", count, saidaUla);
        end
        drive(1'b0, 1'b1, 16'h0000);
        total++;
        if (count !== 3'd1 || saidaUla !== 16'hABCD) begin
            bad++; $display("FAIL pop_head got count=%0d head=%h want count=1 head=abcd", count, saidaUla);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, W'(i));
        total++;
        if (cheio !== 1'b1 || erro !== 1'b0) begin bad++; $display("FAIL full_flag got cheio=%b erro=%b want 1 0", cheio, erro); end
        drive(1'b1, 1'b0, 16'd5);
        total++;
        if (erro !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL overflow got erro=%b count=%0d want 1 4", erro, count); end
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (saidaUla !== W'(i)) begin bad++; $display("FAIL drain_%0d got=%h want=%h", i, saidaUla, W'(i)); end
            drive(1'b0, 1'b1, 16'h0000);
        end
        total++;
        if (saidaUla !== 16'h0000 || vazio !== 1'b1) begin bad++; $display("FAIL drained got head=%h vazio=%b want 0000 1", saidaUla, vazio); end
        // Pointers have wrapped back to slot 0; the next word must still land at the head.
        drive(1'b1, 1'b0, 16'h0BEE);
        total++;
        if (saidaUla !== 16'h0BEE || count !== 3'd1) begin bad++; $display("FAIL wrap_push got head=%h count=%0d want 0bee 1", saidaUla, count); end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, W'(i));
        drive(1'b1, 1'b1, 16'd9);
        total++;
        if (count !== 3'd4 || erro !== 1'b0 || saidaUla !== 16'd2) begin
            bad++; $display("FAIL full_pushpop got count=%0d erro=%b head=%h want 4 0 0002", count, erro, saidaUla);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'h0000);
        total++;
        if (saidaUla !== 16'd9 || count !== 3'd1) begin bad++; $display("FAIL full_pushpop_tail got head=%h count=%0d want 0009 1", saidaUla, count); end
    endtask

    task automatic test_empty_simul();
        do_reset();
        drive(1'b1, 1'b1, 16'd7);
        total++;
        if (count !== 3'd1 || saidaUla !== 16'd7 || erro !== 1'b1) begin
            bad++; $display("FAIL empty_pushpop got count=%0d head=%h erro=%b want 1 0007 1", count, saidaUla, erro);
        end
        do_reset();
        drive(1'b0, 1'b1, 16'h0000);
        total++;
        if (erro !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL underflow got erro=%b count=%0d want 1 0", erro, count); end
        tick();
        total++;
        if (erro !== 1'b1) begin bad++; $display("FAIL erro_sticky got=%b want=1", erro); end
    endtask

    task automatic test_readback();
        logic [W-1:0] exp_bus;
        do_reset();
        drive(1'b1, 1'b0, 16'h00FF);
        io = 1'b1; ler = 1'b1; push = 1'b1;
`ifdef TEMP_READBACK_EN
        bus_en = 1'b0; exp_bus = 16'h00FF;
`else
        bus_en = 1'b1; bus_drv = PROBE; exp_bus = PROBE;
`endif
        #1;
        total++;
        if (Data !== exp_bus) begin bad++; $display("FAIL readback_bus got=%h want=%h", Data, exp_bus); end
        tick();
        total++;
        if (count !== 3'd1 || erro !== 1'b0 || saidaUla !== 16'h00FF) begin
            bad++; $display("FAIL readback_nopop got count=%0d erro=%b head=%h want 1 0 00ff", count, erro, saidaUla);
        end
        push = 1'b0;
        io = 1'b0; bus_en = 1'b1; bus_drv = PROBE;
        #1;
        total++;
        if (Data !== PROBE) begin bad++; $display("FAIL release_on_io got=%h want=%h", Data, PROBE); end
        ler = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] mq[$];
        bit           merr;
        bit           do_pop, do_push;
        logic [W-1:0] exp_bus, exp_head;
        do_reset();
        merr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            push    = ($urandom_range(0, 99) < 55);
            pop     = ($urandom_range(0, 99) < 40);
            io      = ($urandom_range(0, 99) < 20);
            ler     = $urandom_range(0, 1) == 1;
            bus_drv = W'($urandom);
            bus_en  = 1'b1;
            if (!io) begin
                exp_bus = bus_drv;
            end else begin
`ifdef TEMP_READBACK_EN
                if (ler && mq.size() > 0) begin
                    bus_en = 1'b0; exp_bus = mq[0];
                end else begin
                    bus_drv = PROBE; exp_bus = PROBE;
                end
`else
                bus_drv = PROBE; exp_bus = PROBE;
`endif
            end
            #1;
            total++;
            if (Data !== exp_bus) begin bad++; $display("FAIL rnd_bus c=%0d got=%h want=%h", c, Data, exp_bus); end

            do_pop  = pop && mq.size() > 0;
            do_push = push && !io && (mq.size() < DEPTH || do_pop);
            if (pop && mq.size() == 0) merr = 1'b1;
            if (push && !io && mq.size() == DEPTH && !do_pop) merr = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(bus_drv);

            tick();
            exp_head = (mq.size() > 0) ? mq[0] : '0;
            total++;
            if (saidaUla !== exp_head) begin bad++; $display("FAIL rnd_head c=%0d got=%h want=%h", c, saidaUla, exp_head); end
            total++;
            if (count !== (PTR_W+1)'(mq.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, mq.size()); end
            total++;
            if ({vazio, cheio, erro} !== {mq.size() == 0, mq.size() == DEPTH, merr}) begin
                bad++; $display("FAIL rnd_flags c=%0d got=%b want=%b", c, {vazio, cheio, erro},
                                {mq.size() == 0, mq.size() == DEPTH, merr});
            end
            // Occasionally clear the sticky flag so later errors are observable again.
            if ($urandom_range(0, 99) < 3) begin
                push = 1'b0; pop = 1'b0;
                do_reset();
                mq.delete();
                merr = 1'b0;
            end
        end
        push = 1'b0; pop = 1'b0; io = 1'b0; ler = 1'b0; bus_en = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_push_pop();
        test_full_wrap();
        test_full_simul();
        test_empty_simul();
        test_readback();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
